// File: rtl/pipe_wb_regfile.sv
// Write-back stage: commits MEM/WB results to the GPR file and HI/LO, and serves decode reads.
// Define WB_BYPASS_EN for write-first read bypass on the GPR, HI and LO outputs.
module pipe_wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mux_rf_DMEM,
    input  logic              rf_wena,
    input  logic [ADDR_W-1:0] rf_waddr,
    input  logic              hi_ena,
    input  logic [DATA_W-1:0] hi_idata,
    input  logic              lo_ena,
    input  logic [DATA_W-1:0] lo_idata,
    input  logic [DATA_W-1:0] exe_out,
    input  logic [DATA_W-1:0] DMEM_rdata,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] hi_odata,
    output logic [DATA_W-1:0] lo_odata,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       wb_count
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr_q [NumRegs];
    logic [DATA_W-1:0] gpr_d [NumRegs];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [31:0]       wb_count_q, wb_count_d;
    logic              gpr_we;

    assign wb_data = mux_rf_DMEM ? DMEM_rdata : exe_out;
    assign gpr_we  = rf_wena && (rf_waddr != '0);

    always_comb begin
        gpr_d      = gpr_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        wb_count_d = wb_count_q;
        if (gpr_we) begin
            gpr_d[rf_waddr] = wb_data;
            wb_count_d      = wb_count_q + 32'd1;
        end
        // R0 is hardwired; never let a write land there.
        gpr_d[0] = '0;
        if (hi_ena) hi_d = hi_idata;
        if (lo_ena) lo_d = lo_idata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) gpr_q[i] <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            wb_count_q <= '0;
        end else begin
            gpr_q      <= gpr_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            wb_count_q <= wb_count_d;
        end
    end

    always_comb begin
        rs_data  = (rs_addr == '0) ? '0 : gpr_q[rs_addr];
        rt_data  = (rt_addr == '0) ? '0 : gpr_q[rt_addr];
        hi_odata = hi_q;
        lo_odata = lo_q;
`ifdef WB_BYPASS_EN
        // Write-first: decode sees the value being committed this cycle.
        if (gpr_we && (rf_waddr == rs_addr)) rs_data = wb_data;
        if (gpr_we && (rf_waddr == rt_addr)) rt_data = wb_data;
        if (hi_ena) hi_odata = hi_idata;
        if (lo_ena) lo_odata = lo_idata;
`endif
    end

    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Directed self-checking bench for pipe_wb_regfile: vector table plus hand sequences
// for same-cycle read/write and asynchronous reset during a write.
module tb_pipe_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mux_rf_DMEM = 1'b0;
    logic        rf_wena = 1'b0;
    logic [4:0]  rf_waddr = '0;
    logic        hi_ena = 1'b0;
    logic [31:0] hi_idata = '0;
    logic        lo_ena = 1'b0;
    logic [31:0] lo_idata = '0;
    logic [31:0] exe_out = '0;
    logic [31:0] DMEM_rdata = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data, rt_data, hi_odata, lo_odata, wb_data, wb_count;

    int total = 0;
    int bad   = 0;

    pipe_wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .mux_rf_DMEM(mux_rf_DMEM),
        .rf_wena    (rf_wena),
        .rf_waddr   (rf_waddr),
        .hi_ena     (hi_ena),
        .hi_idata   (hi_idata),
        .lo_ena     (lo_ena),
        .lo_idata   (lo_idata),
        .exe_out    (exe_out),
        .DMEM_rdata (DMEM_rdata),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .hi_odata   (hi_odata),
        .lo_odata   (lo_odata),
        .wb_data    (wb_data),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wena;
        logic [4:0]  waddr;
        logic        mux;
        logic [31:0] exe;
        logic [31:0] dmem;
        logic        hen;
        logic [31:0] hdat;
        logic        len;
        logic [31:0] ldat;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_wb;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rf_wena = 1'b0;
        hi_ena  = 1'b0;
        lo_ena  = 1'b0;
    endtask

    logic [31:0] exp_pre;
    logic [31:0] exp_hi_pre;

    initial begin
        vecs[0] = '{1'b1, 5'd3,  1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b0, 32'h0,
                    5'd3, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'd1};
        vecs[1] = '{1'b1, 5'd3,  1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b0, 32'h0,
                    5'd3, 5'd0,  32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0, 32'h0, 32'h0, 32'd2};
        vecs[2] = '{1'b1, 5'd0,  1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    5'd0, 5'd3,  32'hFFFFFFFF, 32'h0, 32'h5A5A5A5A, 32'h0, 32'h0, 32'd2};
        vecs[3] = '{1'b0, 5'd3,  1'b0, 32'h0, 32'h0, 1'b1, 32'h11112222, 1'b1, 32'h33334444,
                    5'd3, 5'd0,  32'h0, 32'h5A5A5A5A, 32'h0, 32'h11112222, 32'h33334444, 32'd2};
        vecs[4] = '{1'b1, 5'd7,  1'b0, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    5'd7, 5'd3,  32'h1, 32'h1, 32'h5A5A5A5A, 32'h11112222, 32'h33334444, 32'd3};
        vecs[5] = '{1'b1, 5'd31, 1'b1, 32'h0, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0,
                    5'd31, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'h1, 32'hCAFEF00D, 32'h33334444,
                    32'd4};
        vecs[6] = '{1'b0, 5'd7,  1'b0, 32'h99, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    5'd7, 5'd31, 32'h99, 32'h1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h33334444, 32'd4};

        // Reset state
        rs_addr = 5'd3;
        rt_addr = 5'd31;
        #12;
        chk("rst_rs", rs_data, 32'h0);
        chk("rst_rt", rt_data, 32'h0);
        chk("rst_hi", hi_odata, 32'h0);
        chk("rst_lo", lo_odata, 32'h0);
        chk("rst_cnt", wb_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rf_wena     = vecs[i].wena;
            rf_waddr    = vecs[i].waddr;
            mux_rf_DMEM = vecs[i].mux;
            exe_out     = vecs[i].exe;
            DMEM_rdata  = vecs[i].dmem;
            hi_ena      = vecs[i].hen;
            hi_idata    = vecs[i].hdat;
            lo_ena      = vecs[i].len;
            lo_idata    = vecs[i].ldat;
            #1;
            chk($sformatf("v%0d_wb", i), wb_data, vecs[i].exp_wb);
            @(posedge clk);
            #1;
            idle_inputs();
            rs_addr = vecs[i].rs;
            rt_addr = vecs[i].rt;
            #1;
            chk($sformatf("v%0d_rs", i), rs_data, vecs[i].exp_rs);
            chk($sformatf("v%0d_rt", i), rt_data, vecs[i].exp_rt);
            chk($sformatf("v%0d_hi", i), hi_odata, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), lo_odata, vecs[i].exp_lo);
            chk($sformatf("v%0d_cnt", i), wb_count, vecs[i].exp_cnt);
        end

        // Same-cycle read/write of GPR[7] (holds 0x1) and HI (holds 0xCAFEF00D)
`ifdef WB_BYPASS_EN
        exp_pre    = 32'h2;
        exp_hi_pre = 32'h77;
`else
        exp_pre    = 32'h1;
        exp_hi_pre = 32'hCAFEF00D;
`endif
        @(negedge clk);
        rf_wena     = 1'b1;
        rf_waddr    = 5'd7;
        mux_rf_DMEM = 1'b0;
        exe_out     = 32'h2;
        hi_ena      = 1'b1;
        hi_idata    = 32'h77;
        rs_addr     = 5'd7;
        rt_addr     = 5'd7;
        #1;
        chk("rw_pre_rs", rs_data, exp_pre);
        chk("rw_pre_rt", rt_data, exp_pre);
        chk("rw_pre_hi", hi_odata, exp_hi_pre);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        chk("rw_post_rs", rs_data, 32'h2);
        chk("rw_post_rt", rt_data, 32'h2);
        chk("rw_post_hi", hi_odata, 32'h77);
        chk("rw_post_cnt", wb_count, 32'd5);

        // Commit GPR[5]=0x1234, then assert reset mid-cycle during another write to it
        @(negedge clk);
        rf_wena  = 1'b1;
        rf_waddr = 5'd5;
        exe_out  = 32'h1234;
        @(posedge clk);
        #1;
        idle_inputs();
        rs_addr = 5'd5;
        #1;
        chk("pre_rst_r5", rs_data, 32'h1234);
        @(negedge clk);
        rf_wena  = 1'b1;
        rf_waddr = 5'd5;
        exe_out  = 32'h5678;
        lo_ena   = 1'b1;
        lo_idata = 32'hABCD;
        #2;
        rst = 1'b1;
        #1;
        rf_wena = 1'b0;
        lo_ena  = 1'b0;
        rt_addr = 5'd7;
        #1;
        chk("arst_rs5", rs_data, 32'h0);
        chk("arst_rt7", rt_data, 32'h0);
        chk("arst_hi", hi_odata, 32'h0);
        chk("arst_lo", lo_odata, 32'h0);
        chk("arst_cnt", wb_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rs5", rs_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
